// File: rtl/voice_gen_pkg.sv
// Shared types and constants for the voice sample generator.
// Ports: none (package). Provides NUM_VOICES, SAMPLE_W, state_t, slot_lsb().
package voice_gen_pkg;

    localparam int NUM_VOICES = 8;
    localparam int SAMPLE_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of voice i inside the packed sample bundle.
    function automatic int slot_lsb(input int i);
        return SAMPLE_W * i;
    endfunction

endpackage

// File: rtl/voice_sample_gen_if.sv
// Request/bundle handshake between superposition and the voice generator.
// master: drives request, note_on, phase_step; slave: drives samples, ready, busy.
interface voice_sample_gen_if
    import voice_gen_pkg::*;
#(
    parameter int PHASE_W = 20
);
    logic                           generate_new_sample;
    logic [NUM_VOICES-1:0]          note_on;
    logic [NUM_VOICES*PHASE_W-1:0]  phase_step;
    logic [NUM_VOICES*SAMPLE_W-1:0] samples;
    logic                           new_sample_ready;
    logic                           busy;

    modport master (
        output generate_new_sample,
        output note_on,
        output phase_step,
        input  samples,
        input  new_sample_ready,
        input  busy
    );

    modport slave (
        input  generate_new_sample,
        input  note_on,
        input  phase_step,
        output samples,
        output new_sample_ready,
        output busy
    );
endinterface

// File: rtl/sine_rom.sv
// Full-period sine wavetable, round(32767*sin(2*pi*k/2^ADDR_W)), one-cycle read.
// Ports: clk, addr (ADDR_W) in; data (16-bit signed) out, registered.
module sine_rom
    import voice_gen_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic [ADDR_W-1:0]          addr,
    output logic signed [SAMPLE_W-1:0] data
);
    localparam int DEPTH = 1 << ADDR_W;

    // Elaboration-time table entry; rounds half away from zero.
    function automatic logic signed [SAMPLE_W-1:0] sine_at(input int k);
        real ang;
        real v;
        int  r;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(DEPTH);
        v   = 32767.0 * $sin(ang);
        if (v >= 0.0) begin
            r = $rtoi(v + 0.5);
        end else begin
            r = -$rtoi(0.5 - v);
        end
        return SAMPLE_W'(r);
    endfunction

    logic signed [SAMPLE_W-1:0] table_q [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_tab
        assign table_q[k] = sine_at(k);
    end

    always_ff @(posedge clk) begin
        data <= table_q[addr];
    end
endmodule

// File: rtl/voice_sample_gen.sv
// Eight-voice wavetable sample generator; voices share one sine ROM port.
// Ports: clk, reset_n (sync, active low), bus (voice_sample_gen_if.slave).
// Optional: define VOICE_SAMPLE_GEN_DECAY_EN for per-voice amplitude decay.
module voice_sample_gen
    import voice_gen_pkg::*;
#(
    parameter int PHASE_W = 20,
    parameter int ADDR_W  = 10
`ifdef VOICE_SAMPLE_GEN_DECAY_EN
    ,
    parameter int DECAY_PERIOD = 4096
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    voice_sample_gen_if.slave   bus
);
    state_t state;
    state_t state_next;

    logic [3:0]                       idx;
    logic [2:0]                       cap;
    logic [PHASE_W-1:0]               phase [NUM_VOICES];
    logic [NUM_VOICES-1:0]            on_q;
    logic [NUM_VOICES*PHASE_W-1:0]    step_q;
    logic signed [SAMPLE_W-1:0]       slot [NUM_VOICES];
    logic [NUM_VOICES*SAMPLE_W-1:0]   samples_q;
    logic                             ready_q;
    logic [ADDR_W-1:0]                rom_addr;
    logic signed [SAMPLE_W-1:0]       rom_data;
    logic signed [SAMPLE_W-1:0]       cap_data;

    sine_rom #(.ADDR_W(ADDR_W)) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // At idx 8 the address wraps to voice 0; that read is never captured.
    always_comb begin
        rom_addr = phase[idx[2:0]][PHASE_W-1 -: ADDR_W];
        cap      = idx[2:0] - 3'd1;
    end

`ifdef VOICE_SAMPLE_GEN_DECAY_EN
    localparam int CNT_W = $clog2(DECAY_PERIOD + 1);

    logic [3:0]            atten [NUM_VOICES];
    logic [NUM_VOICES-1:0] prev_on;
    logic [CNT_W-1:0]      period_cnt;
    logic                  tick;

    assign tick = (period_cnt == CNT_W'(DECAY_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period_cnt <= '0;
            prev_on    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                atten[i] <= '0;
            end
        end else if (state == DONE) begin
            period_cnt <= tick ? '0 : period_cnt + CNT_W'(1);
            prev_on    <= on_q;
            for (int i = 0; i < NUM_VOICES; i++) begin
                // A fresh note-on restores full amplitude.
                if (on_q[i] && !prev_on[i]) begin
                    atten[i] <= '0;
                end else if (tick && on_q[i] && atten[i] != 4'd15) begin
                    atten[i] <= atten[i] + 4'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        cap_data = '0;
        if (on_q[cap]) begin
`ifdef VOICE_SAMPLE_GEN_DECAY_EN
            cap_data = rom_data >>> atten[cap];
`else
            cap_data = rom_data;
`endif
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.generate_new_sample) state_next = RUN;
            RUN:     if (idx == 4'd8) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            idx       <= '0;
            ready_q   <= 1'b0;
            samples_q <= '0;
            on_q      <= '0;
            step_q    <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
                slot[i]  <= '0;
            end
        end else begin
            state   <= state_next;
            ready_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.generate_new_sample) begin
                        on_q   <= bus.note_on;
                        step_q <= bus.phase_step;
                        idx    <= '0;
                    end
                end
                RUN: begin
                    idx <= idx + 4'd1;
                    // ROM data lags the address by one edge.
                    if (idx != 4'd0) begin
                        slot[cap] <= cap_data;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        samples_q[slot_lsb(i) +: SAMPLE_W] <= slot[i];
                        if (on_q[i]) begin
                            phase[i] <= phase[i]
                                + step_q[PHASE_W*i +: PHASE_W];
                        end else begin
                            phase[i] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.samples          = samples_q;
    assign bus.new_sample_ready = ready_q;
    assign bus.busy             = (state != IDLE);
endmodule

// File: tb/tb_voice_sample_gen.sv
// Directed self-checking bench for voice_sample_gen.
// Ports: none; drives the DUT through a voice_sample_gen_if instance.
module tb_voice_sample_gen;
    import voice_gen_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    voice_sample_gen_if #(.PHASE_W(20)) bus ();

    voice_sample_gen dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] one_voice(input int v,
                                               input logic [15:0] s);
        logic [127:0] b;
        b = '0;
        b[slot_lsb(v) +: 16] = s;
        return b;
    endfunction

    // Single-cycle request; checks latency, busy span, bundle, pulse width.
    task automatic request(input string tag, input logic [127:0] exp);
        int n;
        int bc;
        bus.generate_new_sample = 1'b1;
        tick();
        bus.generate_new_sample = 1'b0;
        n  = 0;
        bc = 0;
        if (bus.busy) bc++;
        while (!bus.new_sample_ready && n < 40) begin
            tick();
            n++;
            if (bus.busy) bc++;
        end
        check({tag, " latency"}, 128'(n), 128'd10);
        check({tag, " busy"}, 128'(bc), 128'd10);
        check({tag, " samples"}, bus.samples, exp);
        tick();
        check({tag, " width"}, 128'(bus.new_sample_ready), 128'd0);
    endtask

    initial begin
        int n;
        int m;
        int pulses;
        logic [127:0] e;

        bus.generate_new_sample = 1'b0;
        bus.note_on = '0;
        bus.phase_step = '0;

        // Reset
        reset_n = 1'b0;
        tick();
        tick();
        check("rst samples", bus.samples, 128'd0);
        check("rst ready", 128'(bus.new_sample_ready), 128'd0);
        check("rst busy", 128'(bus.busy), 128'd0);
        reset_n = 1'b1;
        tick();

        // All voices off
        request("off", 128'd0);

        // Quarter-period step on voice 0
        bus.note_on = 8'h01;
        bus.phase_step = '0;
        bus.phase_step[19:0] = 20'h40000;
        request("q0", one_voice(0, 16'h0000));
        request("q1", one_voice(0, 16'h7FFF));
        request("q2", one_voice(0, 16'h0000));
        request("q3", one_voice(0, 16'h8001));

        // Three-quarter step on voice 7, phase wraps
        bus.note_on = 8'h80;
        bus.phase_step = '0;
        bus.phase_step[7*20 +: 20] = 20'hC0000;
        request("t0", one_voice(7, 16'h0000));
        request("t1", one_voice(7, 16'h8001));
        request("t2", one_voice(7, 16'h0000));
        request("t3", one_voice(7, 16'h7FFF));

        // Request held high: one pulse, next bundle 11 cycles later
        bus.note_on = 8'h01;
        bus.phase_step = '0;
        bus.phase_step[19:0] = 20'h40000;
        bus.generate_new_sample = 1'b1;
        tick();
        n = 0;
        while (!bus.new_sample_ready && n < 40) begin
            tick();
            n++;
        end
        check("hold latency", 128'(n), 128'd10);
        check("hold samples", bus.samples, one_voice(0, 16'h0000));
        tick();
        bus.generate_new_sample = 1'b0;
        check("hold width", 128'(bus.new_sample_ready), 128'd0);
        check("hold restart", 128'(bus.busy), 128'd1);
        m = 1;
        while (!bus.new_sample_ready && m < 40) begin
            tick();
            m++;
        end
        check("hold spacing", 128'(m), 128'd11);
        check("hold samples2", bus.samples, one_voice(0, 16'h7FFF));
        tick();

        // Reset in the middle of RUN (idx 5)
        bus.generate_new_sample = 1'b1;
        tick();
        bus.generate_new_sample = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid busy", 128'(bus.busy), 128'd0);
        check("mid ready", 128'(bus.new_sample_ready), 128'd0);
        check("mid samples", bus.samples, 128'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.new_sample_ready) pulses++;
        end
        check("mid no pulse", 128'(pulses), 128'd0);
        request("mid r0", one_voice(0, 16'h0000));
        request("mid r1", one_voice(0, 16'h7FFF));

        // Two voices at once, checking slot placement
        bus.note_on = 8'h24;
        bus.phase_step = '0;
        bus.phase_step[2*20 +: 20] = 20'h40000;
        bus.phase_step[5*20 +: 20] = 20'hC0000;
        request("dual0", 128'd0);
        e = one_voice(2, 16'h7FFF) | one_voice(5, 16'h8001);
        request("dual1", e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/voice_sample_gen.md
Name: voice_sample_gen

Overview:
Upstream stage of superposition. Produces the 128-bit bundle of eight signed 16-bit voice samples that superposition sums into out_sample. Handshake:
- superposition pulses generate_new_sample to request a bundle.
- This block reads each voice's phase from a shared sine wavetable, voices serialised through one ROM port.
- It registers the bundle onto samples and pulses new_sample_ready.

Parameters:
- PHASE_W, 20, phase accumulator / step width per voice.
- ADDR_W, 10, wavetable address width; the ROM holds 2^ADDR_W entries.
- DECAY_PERIOD, 4096, sample requests per attenuation step (only used with DECAY_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  synchronous active-low reset.
- generate_new_sample  in  1  request for a new bundle, level-sampled in IDLE.
- note_on  in  8  per-voice enable; bit i controls voice i.
- phase_step  in  8*PHASE_W  per-voice phase increment; voice i at [PHASE_W*i +: PHASE_W].
- samples  out  128  voice i at [16*i +: 16], signed two's complement.
- new_sample_ready  out  1  one-cycle pulse, samples updated.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset (reset_n==0 at an edge), overriding all else, including mid-run:
  - state IDLE, samples=0, new_sample_ready=0, all phases=0, idx=0.
  - a bundle in progress is discarded; no pulse is produced.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On an edge with generate_new_sample=1, latch note_on and phase_step into shadow registers, idx=0, go to RUN.
  - Otherwise hold.
- RUN, idx 0..8:
  - ROM address is combinationally phase[idx][PHASE_W-1 -: ADDR_W] for idx<8.
  - The ROM has a one-cycle registered read.
  - On each edge with idx>=1, capture rom_data into shadow slot idx-1. The slot is forced to 0 if the latched note_on bit is 0.
  - idx increments each edge. The edge with idx==8 captures voice 7 and goes to DONE.
- DONE (one cycle):
  - Copy shadow to samples; new_sample_ready=1 for exactly the next cycle.
  - For each voice: phase[i] <= (phase[i]+step[i]) mod 2^PHASE_W if latched note_on[i], else phase[i] <= 0.
  - Go to IDLE.
- Latency: request seen at edge E0; samples valid and new_sample_ready high from E10 to E11. Steady-state throughput is one bundle per 11 cycles.
- generate_new_sample during RUN/DONE is ignored (not queued). A request held high across the pulse starts a new bundle at the first IDLE edge.
- samples holds between DONE cycles. new_sample_ready is otherwise 0.
- The first bundle after a voice is enabled uses phase 0, so that slot is rom[0]=0.
- ROM contents: rom[k] = round(32767*sin(2*pi*k/2^ADDR_W)), range +-32767; 0x8000 is never produced.
- No saturation or scaling here. Amplitude headroom for the 8-way sum is superposition's responsibility.

Optional Feature:
- VOICE_SAMPLE_GEN_DECAY_EN defined:
  - Per-voice 4-bit attenuation atten[i].
  - atten[i] is cleared in DONE when latched note_on[i] is 1 and was 0 in the previous bundle.
  - Every DECAY_PERIOD completed bundles, each active voice's atten increments, saturating at 15.
  - Captured slot = rom_data >>> atten[i] (arithmetic shift).
  - Reset clears atten and the period counter.
- Not defined: full amplitude; no attenuation or counter logic synthesised.

Decomposition:
- Package voice_gen_pkg holds:
  - NUM_VOICES=8 and SAMPLE_W=16;
  - FSM state encoding (IDLE/RUN/DONE);
  - function packing/unpacking the slot offset 16*i.
- One sub-module, sine_rom: ADDR_W-bit address in, 16-bit signed data out, registered read latency 1, contents generated by function/initial block.

Test Plan:
- Reset: hold reset_n=0 two cycles -> samples=0, new_sample_ready=0, busy=0.
- note_on=8'h00, single-cycle request -> busy for 10 cycles; new_sample_ready pulses at cycle 10 after request, one cycle wide; samples=128'd0.
- Quarter-period step, 4 successive requests:
  - stimulus: note_on=8'h01, phase_step voice0=20'h40000.
  - voice0 slot sequence 16'h0000, 16'h7FFF, 16'h0000, 16'h8001; other slots 0.
- Three-quarter step (wrap-around check):
  - stimulus: note_on=8'h80, voice7 step=20'hC0000, 4 requests.
  - voice7 sequence 16'h0000, 16'h8001, 16'h0000, 16'h7FFF.
- Request re-asserted every cycle for 10 cycles after the first -> exactly one pulse at cycle 10. A second bundle starts at the IDLE edge after DONE; its pulse arrives 11 cycles after the first.
- Reset mid-run: reset_n=0 at RUN idx=5 -> no pulse; busy=0 next cycle; samples retains 0; a subsequent request completes normally with phases restarted at 0.
